// File: rtl/aemb2_sfrf_mt.sv
// aemb2_sfrf_mt: per-thread MSR/ESR/EAR banks, round-robin thread phase, MFS read registered into EX.
// Optional macro AEMB_SFRF_PVR_EN maps PVR_VAL at MFS address 14'h2000.
module aemb2_sfrf_mt #(
    parameter int          THD_W   = 1,
    parameter logic [31:0] PVR_VAL = 32'h0000_0000
) (
    input  logic        gclk,
    input  logic        grst,
    input  logic        dena,
    input  logic [5:0]  opc_of,
    input  logic [15:0] imm_of,
    input  logic [4:0]  ra_of,
    input  logic [4:0]  rd_of,
    input  logic [31:0] opa_of,
    input  logic        alu_c,
    input  logic        alu_cwe,
    input  logic        exc_req,
    input  logic [4:0]  exc_ec,
    input  logic [31:0] exc_ea,
    output logic        exc_ack,
    output logic [31:0] sfr_ex,
    output logic [((THD_W == 0) ? 1 : THD_W)-1:0] thd_id,
    output logic        msr_ie,
    output logic        msr_bip,
    output logic        msr_ice,
    output logic        msr_dce,
    output logic        msr_eip
);
    localparam int TW = (THD_W == 0) ? 1 : THD_W;
    localparam int NT = 1 << THD_W;

`ifdef AEMB_SFRF_PVR_EN
    localparam logic [31:0] L_PVR = PVR_VAL;
`else
    localparam logic [31:0] L_PVR = PVR_VAL & 32'h0;
`endif

    logic [TW-1:0] r_thd;
    logic          r_c   [NT];
    logic          r_ie  [NT];
    logic          r_bip [NT];
    logic          r_ice [NT];
    logic          r_dce [NT];
    logic          r_be  [NT];
    logic          r_eip [NT];
    logic [4:0]    r_esr [NT];
    logic [31:0]   r_ear [NT];

    logic [TW-1:0] w_thd_nxt;
    logic [31:0]   w_view;
    logic [13:0]   w_mop_res;
    logic [31:0]   w_mfs_dat;
    logic          w_mov, w_mts, w_mop, w_mfs;
    logic          w_rtid, w_rtbd, w_rted, w_brki, w_brk;
    logic          w_exc_take;
    logic          w_ie_nxt, w_bip_nxt, w_ice_nxt, w_dce_nxt, w_be_nxt;
    logic          w_unused;

    assign w_thd_nxt = (THD_W == 0) ? '0 : r_thd + 1'b1;

    assign w_view = {r_c[r_thd], (THD_W != 0), 3'(r_thd), 17'd0,
                     r_eip[r_thd], 1'b0, r_dce[r_thd], 1'b0, r_ice[r_thd], 1'b0,
                     r_bip[r_thd], r_c[r_thd], r_ie[r_thd], r_be[r_thd]};

    assign w_mov  = (opc_of == 6'o45);
    assign w_mts  = w_mov && (imm_of[15:14] == 2'b11);
    assign w_mop  = w_mov && (imm_of[15:14] == 2'b00);
    assign w_mfs  = w_mov && (imm_of[15:14] == 2'b10);
    assign w_rtid = (opc_of == 6'o55) && rd_of[0];
    assign w_rtbd = (opc_of == 6'o55) && rd_of[1];
    assign w_rted = (opc_of == 6'o55) && rd_of[2];
    assign w_brki = (opc_of == 6'o56) && (ra_of == 5'hD);
    assign w_brk  = ((opc_of == 6'o46) || (opc_of == 6'o56)) && (ra_of == 5'hC);

    assign w_mop_res  = ra_of[0] ? (w_view[13:0] & ~imm_of[13:0]) : (w_view[13:0] | imm_of[13:0]);
    assign w_exc_take = exc_req && !r_eip[r_thd];

    always_comb begin
        w_ie_nxt  = r_ie[r_thd];
        w_bip_nxt = r_bip[r_thd];
        w_ice_nxt = r_ice[r_thd];
        w_dce_nxt = r_dce[r_thd];
        w_be_nxt  = r_be[r_thd];
        if (w_mop) begin
            w_ie_nxt  = w_mop_res[1];
            w_bip_nxt = w_mop_res[3];
            w_ice_nxt = w_mop_res[5];
            w_dce_nxt = w_mop_res[7];
            w_be_nxt  = w_mop_res[0];
        end
        if (w_mts) begin
            w_ie_nxt  = opa_of[1];
            w_bip_nxt = opa_of[3];
            w_ice_nxt = opa_of[5];
            w_dce_nxt = opa_of[7];
            w_be_nxt  = opa_of[0];
        end
        if (w_rtid) w_ie_nxt = 1'b1;
        if (w_brki) w_ie_nxt = 1'b0;
        if (w_rtbd) w_bip_nxt = 1'b0;
        if (w_brk)  w_bip_nxt = 1'b1;
    end

    always_comb begin
        w_mfs_dat = w_view;
        if (w_mfs) begin
            case (imm_of[13:0])
                14'h0001: w_mfs_dat = w_view;
                14'h0003: w_mfs_dat = r_ear[r_thd];
                14'h0005: w_mfs_dat = {27'd0, r_esr[r_thd]};
                14'h2000: w_mfs_dat = L_PVR;
                default:  w_mfs_dat = 32'd0;
            endcase
        end
    end

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            r_thd   <= '0;
            sfr_ex  <= 32'd0;
            exc_ack <= 1'b0;
            for (int t = 0; t < NT; t++) begin
                r_c[t]   <= 1'b0;
                r_ie[t]  <= 1'b0;
                r_bip[t] <= 1'b0;
                r_ice[t] <= 1'b0;
                r_dce[t] <= 1'b0;
                r_be[t]  <= 1'b0;
                r_eip[t] <= 1'b0;
                r_esr[t] <= 5'd0;
                r_ear[t] <= 32'd0;
            end
        end else if (dena) begin
            r_thd        <= w_thd_nxt;
            sfr_ex       <= w_mfs_dat;
            exc_ack      <= w_exc_take;
            r_ie[r_thd]  <= w_ie_nxt;
            r_bip[r_thd] <= w_bip_nxt;
            r_ice[r_thd] <= w_ice_nxt;
            r_dce[r_thd] <= w_dce_nxt;
            r_be[r_thd]  <= w_be_nxt;
            if (alu_cwe) r_c[r_thd] <= alu_c;
            // a pending request keeps EIP set even when RTED arrives alongside it
            if (w_exc_take) begin
                r_eip[r_thd] <= 1'b1;
                r_esr[r_thd] <= exc_ec;
                r_ear[r_thd] <= exc_ea;
            end else if (w_rted && !exc_req) begin
                r_eip[r_thd] <= 1'b0;
            end
        end
    end

    assign thd_id  = r_thd;
    assign msr_ie  = r_ie[r_thd];
    assign msr_bip = r_bip[r_thd];
    assign msr_ice = r_ice[r_thd];
    assign msr_dce = r_dce[r_thd];
    assign msr_eip = r_eip[r_thd];

    assign w_unused = ^{rd_of[4:3], opa_of[31:8], opa_of[6], opa_of[4], opa_of[2],
                        w_mop_res[13:8], w_mop_res[6], w_mop_res[4], w_mop_res[2]};
endmodule

// File: tb/tb_aemb2_sfrf_mt.sv
// Directed bench for aemb2_sfrf_mt with four threads; PVR expectation follows AEMB_SFRF_PVR_EN.
module tb_aemb2_sfrf_mt;
    logic        gclk = 1'b0;
    logic        grst, dena;
    logic [5:0]  opc_of;
    logic [15:0] imm_of;
    logic [4:0]  ra_of, rd_of;
    logic [31:0] opa_of;
    logic        alu_c, alu_cwe, exc_req;
    logic [4:0]  exc_ec;
    logic [31:0] exc_ea;
    logic        exc_ack;
    logic [31:0] sfr_ex;
    logic [1:0]  thd_id;
    logic        msr_ie, msr_bip, msr_ice, msr_dce, msr_eip;

    int vectors = 0;
    int miscompares = 0;
    logic [1:0]  exp_thd = 2'd0;
    logic [31:0] exp_pvr;

    aemb2_sfrf_mt #(.THD_W(2), .PVR_VAL(32'hA5A5_0001)) dut (
        .gclk(gclk), .grst(grst), .dena(dena), .opc_of(opc_of), .imm_of(imm_of),
        .ra_of(ra_of), .rd_of(rd_of), .opa_of(opa_of), .alu_c(alu_c), .alu_cwe(alu_cwe),
        .exc_req(exc_req), .exc_ec(exc_ec), .exc_ea(exc_ea), .exc_ack(exc_ack),
        .sfr_ex(sfr_ex), .thd_id(thd_id), .msr_ie(msr_ie), .msr_bip(msr_bip),
        .msr_ice(msr_ice), .msr_dce(msr_dce), .msr_eip(msr_eip)
    );

    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nop_inputs();
        opc_of = 6'd0; imm_of = 16'd0; ra_of = 5'd0; rd_of = 5'd0; opa_of = 32'd0;
        alu_c = 1'b0; alu_cwe = 1'b0; exc_req = 1'b0; exc_ec = 5'd0; exc_ea = 32'd0;
    endtask

    task automatic tick();
        @(posedge gclk);
        #1;
        exp_thd = exp_thd + 2'd1;
        chk("thd_id", {30'd0, thd_id}, {30'd0, exp_thd});
        nop_inputs();
    endtask

    task automatic nop_until(input logic [1:0] t);
        for (int i = 0; i < 4 && exp_thd != t; i++) tick();
    endtask

    function automatic logic [31:0] msr_bits();
        return {27'd0, msr_dce, msr_ice, msr_bip, msr_ie, msr_eip};
    endfunction

    initial begin
`ifdef AEMB_SFRF_PVR_EN
        exp_pvr = 32'hA5A5_0001;
`else
        exp_pvr = 32'h0000_0000;
`endif
        grst = 1'b1; dena = 1'b0;
        nop_inputs();
        #2;
        chk("rst_thd", {30'd0, thd_id}, 32'd0);
        chk("rst_sfr", sfr_ex, 32'd0);
        chk("rst_ack", {31'd0, exc_ack}, 32'd0);
        chk("rst_msr", msr_bits(), 32'd0);
        @(negedge gclk);
        grst = 1'b0; dena = 1'b1;

        // phase rotation 0,1,2,3,0; thread 0 view is HTE only
        tick();
        chk("view_t0", sfr_ex, 32'h4000_0000);
        tick(); tick(); tick();
        chk("msr_idle", msr_bits(), 32'd0);

        // MTS on thread 1, MFS on thread 2
        nop_until(2'd1);
        opc_of = 6'o45; imm_of = 16'hC000; opa_of = 32'h0000_00AB;
        tick();
        opc_of = 6'o45; imm_of = 16'h8001;
        tick();
        chk("mfs_t2", sfr_ex, 32'h5000_0000);
        nop_until(2'd1);
        chk("msr_t1_mts", msr_bits(), 32'h0000_001E);
        opc_of = 6'o45; imm_of = 16'h8001;
        tick();
        chk("mfs_t1", sfr_ex, 32'h4800_00AB);
        chk("msr_t2", msr_bits(), 32'd0);

        // MSRSET / MSRCLR of IE on thread 0
        nop_until(2'd0);
        opc_of = 6'o45; imm_of = 16'h0002; ra_of = 5'd0;
        tick();
        tick();
        chk("ie_t2", {31'd0, msr_ie}, 32'd0);
        tick();
        chk("ie_t3", {31'd0, msr_ie}, 32'd0);
        tick();
        chk("ie_set_t0", {31'd0, msr_ie}, 32'd1);
        opc_of = 6'o45; imm_of = 16'h0002; ra_of = 5'd1;
        tick();
        nop_until(2'd0);
        chk("ie_clr_t0", {31'd0, msr_ie}, 32'd0);

        // exception capture on thread 0
        exc_req = 1'b1; exc_ec = 5'h11; exc_ea = 32'h1234_5678;
        tick();
        chk("exc_ack1", {31'd0, exc_ack}, 32'd1);
        tick();
        chk("exc_ack0", {31'd0, exc_ack}, 32'd0);
        nop_until(2'd0);
        chk("eip_set", {31'd0, msr_eip}, 32'd1);
        opc_of = 6'o45; imm_of = 16'h8005;
        tick();
        chk("mfs_esr", sfr_ex, 32'h0000_0011);
        nop_until(2'd0);
        opc_of = 6'o45; imm_of = 16'h8003;
        tick();
        chk("mfs_ear", sfr_ex, 32'h1234_5678);
        nop_until(2'd0);
        exc_req = 1'b1; exc_ec = 5'h02; exc_ea = 32'h0000_DEAD;
        tick();
        chk("exc_drop", {31'd0, exc_ack}, 32'd0);
        nop_until(2'd0);
        opc_of = 6'o55; rd_of = 5'b00100; exc_req = 1'b1; exc_ec = 5'h03;
        tick();
        chk("rted_exc_ack", {31'd0, exc_ack}, 32'd0);
        nop_until(2'd0);
        chk("rted_exc_eip", {31'd0, msr_eip}, 32'd1);
        opc_of = 6'o55; rd_of = 5'b00100;
        tick();
        nop_until(2'd0);
        chk("rted_eip", {31'd0, msr_eip}, 32'd0);
        opc_of = 6'o45; imm_of = 16'h8005;
        tick();
        chk("esr_kept", sfr_ex, 32'h0000_0011);

        // BRK then RTBD on thread 0
        nop_until(2'd0);
        opc_of = 6'o56; ra_of = 5'hC;
        tick();
        nop_until(2'd0);
        chk("brk_bip", {31'd0, msr_bip}, 32'd1);
        opc_of = 6'o55; rd_of = 5'b00010;
        tick();
        nop_until(2'd0);
        chk("rtbd_bip", {31'd0, msr_bip}, 32'd0);

        // carry write on thread 1
        nop_until(2'd1);
        alu_cwe = 1'b1; alu_c = 1'b1;
        tick();
        nop_until(2'd1);
        opc_of = 6'o45; imm_of = 16'h8001;
        tick();
        chk("carry_view", sfr_ex, 32'hC800_00AF);

        // dena low holds everything, including a presented MSRSET
        dena = 1'b0;
        opc_of = 6'o45; imm_of = 16'h0002;
        @(posedge gclk);
        #1;
        chk("hold_thd", {30'd0, thd_id}, 32'd2);
        chk("hold_sfr", sfr_ex, 32'hC800_00AF);
        chk("hold_ie", {31'd0, msr_ie}, 32'd0);
        nop_inputs();
        dena = 1'b1;

        opc_of = 6'o45; imm_of = 16'hA000;
        tick();
        chk("mfs_pvr", sfr_ex, exp_pvr);
        opc_of = 6'o45; imm_of = 16'h8007;
        tick();
        chk("mfs_unmapped", sfr_ex, 32'd0);

        // asynchronous reset mid-cycle
        nop_until(2'd1);
        @(negedge gclk);
        grst = 1'b1;
        #1;
        exp_thd = 2'd0;
        chk("arst_thd", {30'd0, thd_id}, 32'd0);
        chk("arst_sfr", sfr_ex, 32'd0);
        chk("arst_msr", msr_bits(), 32'd0);
        @(negedge gclk);
        grst = 1'b0;
        tick();
        chk("arst_msr_t1", msr_bits(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/aemb2_sfrf_mt.md
Name: aemb2_sfrf_mt

Overview:
- Multi-thread special function register file for the AEMB2 core, generalising the two-phase MSR block to 2^THD_W hardware threads.
- Holds a per-thread MSR bank plus per-thread exception registers (ESR, EAR).
- Runs a round-robin thread-phase counter.
- Decodes MTS/MFS/MSRSET/MSRCLR/RTID/RTBD/RTED/BRK in the OF stage and returns MFS data registered into EX.

Parameters:
- THD_W, 1, log2 of thread count (0..3); thread count = 2^THD_W; 0 gives a single-thread core.
- PVR_VAL, 32'h0000_0000, processor version value (used only with the optional feature).

Ports:
- gclk  in  1  core clock, rising edge.
- grst  in  1  reset, asynchronous, active-high.
- dena  in  1  pipeline advance enable; all state holds when low.
- opc_of  in  6  OF-stage opcode.
- imm_of  in  16  OF-stage immediate.
- ra_of  in  5  OF-stage RA field.
- rd_of  in  5  OF-stage RD field.
- opa_of  in  32  operand A (MTS source).
- alu_c  in  1  ALU carry-out.
- alu_cwe  in  1  carry write-enable for the current thread.
- exc_req  in  1  exception request for the current thread.
- exc_ec  in  5  exception cause code.
- exc_ea  in  32  exception address.
- exc_ack  out  1  exception accepted (registered pulse).
- sfr_ex  out  32  MFS read data, EX stage.
- thd_id  out  max(THD_W,1)  current thread phase.
- msr_ie  out  1  IE bit of bank thd_id.
- msr_bip  out  1  BIP bit of bank thd_id.
- msr_ice  out  1  ICE bit of bank thd_id.
- msr_dce  out  1  DCE bit of bank thd_id.
- msr_eip  out  1  EIP bit of bank thd_id.

Behaviour:
- Reset (async, grst=1): thd_id=0, sfr_ex=0, exc_ack=0, every bank's C/IE/BIP/ICE/DCE/BE/EIP=0, ESR=0, EAR=0. Assertion mid-operation clears state immediately; no partial updates survive.
- Thread phase: on each gclk edge with dena=1, thd_id <= thd_id+1, wrapping from 2^THD_W-1 to 0. With THD_W=0, thd_id is constant 0. The instruction in OF and all writes target bank thd_id (value before the increment).
- Read view of bank t (32 bits):
  - [31] CC = C
  - [30] HTE = (THD_W!=0)
  - [29:27] thread id, zero-extended
  - [9] EIP
  - [7] DCE
  - [5] ICE
  - [3] BIP
  - [2] C
  - [1] IE
  - [0] BE
  - all other bits 0
- Decode (current bank, dena=1):
  - MOV = opc_of==6'o45.
  - MTS = MOV & imm_of[15:14]==2'b11. Writes DCE/ICE/BIP/IE/BE from opa_of[7,5,3,1,0]. C is not writable by MTS.
  - MOP = MOV & imm_of[15:14]==2'b00. res = msr[13:0] & ~imm_of[13:0] when ra_of[0]=1 (MSRCLR), else msr[13:0] | imm_of[13:0] (MSRSET). Writes bits 7,5,3,1,0 from res.
  - MFS = MOV & imm_of[15:14]==2'b10.
  - RTID = opc_of==6'o55 & rd_of[0]; sets IE=1.
  - RTBD = opc_of==6'o55 & rd_of[1]; clears BIP.
  - RTED = opc_of==6'o55 & rd_of[2]; clears EIP.
  - BRKI = opc_of==6'o56 & ra_of==5'hD; clears IE.
  - BRK  = opc_of in {6'o46, 6'o56} & ra_of==5'hC; sets BIP.
- Per-bit priority:
  - IE: BRKI > RTID > MTS > MOP > hold.
  - BIP: BRK > RTBD > MTS > MOP > hold.
  - ICE/DCE/BE: MTS > MOP > hold.
- Carry: C[thd_id] <= alu_c when alu_cwe=1, else hold. Carry updates take priority over MOP results on bit 2.
- Exceptions: if exc_req & ~EIP[thd_id] & dena:
  - EIP <= 1, ESR <= {27'd0, exc_ec}, EAR <= exc_ea, exc_ack <= 1.
  - Otherwise exc_ack <= 0.
  - exc_req beats RTED on the same cycle and bank (EIP stays 1).
  - A request while EIP=1 is dropped; no ack is issued.
- MFS: sfr_ex <= selected value on the dena cycle, i.e. one-cycle latency.
  - imm_of[13:0]==14'h0001: MSR view of the current bank.
  - 14'h0003: EAR.
  - 14'h0005: ESR.
  - anything else: 0.
  - Non-MFS cycles: sfr_ex <= MSR view (keeps CC visible).
  - The read reflects state before the same-cycle write.
- dena=0: thd_id, banks, sfr_ex and exc_ack all hold.

Optional Feature:
- AEMB_SFRF_PVR_EN defined: MFS with imm_of[13:0]==14'h2000 returns PVR_VAL.
- Undefined: that address returns 0 and PVR_VAL is unused.

Test Plan:
- Reset, then 4 dena cycles with THD_W=2 -> thd_id sequence 0,1,2,3,0; all msr_* 0; sfr_ex=0x4000_0000 (HTE only, thread 0 view).
- Thread 1: MTS opa_of=0x0000_00AB; thread 2: MFS imm 0x8001 -> thread 2 read gives DCE=ICE=BIP=BE=0. Next visit to thread 1 shows msr_dce=1, msr_ice=1, msr_bip=1, msr_ie=1, and BE=1 in its MSR view.
- Thread 0: MSRSET imm 0x0002, then MSRCLR (ra_of=1) imm 0x0002 on its next slot -> msr_ie goes 1 then 0; other threads' IE remain 0.
- Thread 0: exc_req with exc_ec=5'h11, exc_ea=0x1234_5678 -> exc_ack pulses for 1 cycle. MFS 0x8005 then returns 0x11, and MFS 0x8003 returns 0x1234_5678. A second exc_req is not acked. Same-cycle RTED+exc_req leaves EIP=1; RTED alone clears it.
- BRK (opc 6'o56, ra 0xC) and RTBD in separate slots -> BIP 1 then 0. alu_cwe=1, alu_c=1 on thread 1 -> its MSR view shows bits 31 and 2 set.
- With AEMB_SFRF_PVR_EN and PVR_VAL=0xA5A5_0001: MFS 0xA000 -> sfr_ex=0xA5A5_0001. Without the macro -> 0.
